// File: rtl/mem_vec_pkg.sv
// Shared definitions for the vector ALU engine: op encodings, FSM states and
// default parameter values.
package mem_vec_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 6;
    localparam int LEN_W_DEF  = 7;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLT = 3'd5;
    localparam logic [2:0] OP_SLL = 3'd6;
    localparam logic [2:0] OP_SRL = 3'd7;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_B = 3'd2,
        EXEC = 3'd3,
        WR   = 3'd4,
        FIN  = 3'd5
    } state_e;

endpackage

// File: rtl/vec_alu_core.sv
// Combinational op mux for the vector engine. Produces the element result and
// the signed-overflow term, which is only ever non-zero for ADD and SUB.
module vec_alu_core
    import mem_vec_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        op,
    output logic [DATA_W-1:0] res,
    output logic              ovf_bit
);

    logic [DATA_W-1:0] sum_s;
    logic [DATA_W-1:0] diff_s;
    logic [4:0]        shamt_s;
    logic              lt_s;

    assign sum_s   = a + b;
    assign diff_s  = a - b;
    assign shamt_s = b[4:0];
    assign lt_s    = ($signed(a) < $signed(b));

    // Select the result for the requested op and flag signed overflow on ADD/SUB.
    always_comb begin
        res     = {DATA_W{1'b0}};
        ovf_bit = 1'b0;
        case (op)
            OP_ADD: begin
                res     = sum_s;
                ovf_bit = (a[DATA_W-1] == b[DATA_W-1]) && (sum_s[DATA_W-1] != a[DATA_W-1]);
            end
            OP_SUB: begin
                res     = diff_s;
                ovf_bit = (a[DATA_W-1] != b[DATA_W-1]) && (diff_s[DATA_W-1] != a[DATA_W-1]);
            end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_SLT: res = {{(DATA_W-1){1'b0}}, lt_s};
            OP_SLL: res = a << shamt_s;
            OP_SRL: res = a >> shamt_s;
            default: begin
                res     = {DATA_W{1'b0}};
                ovf_bit = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mem_vec_engine.sv
// Sequenced vector ALU engine. For each of len elements it reads A and B through
// the memory read port (one-cycle read latency), applies the selected op and
// writes D through the write port: RD_A, RD_B, EXEC, WR per element, then FIN.
// All outputs are registered; the next-cycle value of each is decided in one
// combinational block so that each output lines up with the state it belongs to.
module mem_vec_engine
    import mem_vec_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [ADDR_W-1:0] base_d,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              ovf,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] dina,
    output logic [ADDR_W-1:0] addrb,
    input  logic [DATA_W-1:0] doutb
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0]  LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    state_e            state_r, state_s;
    logic [2:0]        op_r, op_s;
    logic [ADDR_W-1:0] a_ptr_r, a_ptr_s;
    logic [ADDR_W-1:0] b_ptr_r, b_ptr_s;
    logic [ADDR_W-1:0] d_ptr_r, d_ptr_s;
    logic [LEN_W-1:0]  len_r, len_s;
    logic [LEN_W-1:0]  cnt_r, cnt_s;
    logic [DATA_W-1:0] opa_r, opa_s;
    logic              ovf_r, ovf_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic              wea_r, wea_s;
    logic [ADDR_W-1:0] addra_r, addra_s;
    logic [DATA_W-1:0] dina_r, dina_s;
    logic [ADDR_W-1:0] addrb_r, addrb_s;
    logic [DATA_W-1:0] alu_res_s;
    logic              alu_ovf_s;

    // During EXEC the A operand is held in opa_r and the B operand is on doutb.
    vec_alu_core #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a       (opa_r),
        .b       (doutb),
        .op      (op_r),
        .res     (alu_res_s),
        .ovf_bit (alu_ovf_s)
    );

    // Next-state and next-output decode; every register holds unless its state says otherwise.
    always_comb begin
        state_s = state_r;
        op_s    = op_r;
        a_ptr_s = a_ptr_r;
        b_ptr_s = b_ptr_r;
        d_ptr_s = d_ptr_r;
        len_s   = len_r;
        cnt_s   = cnt_r;
        opa_s   = opa_r;
        ovf_s   = ovf_r;
        busy_s  = 1'b0;
        done_s  = 1'b0;
        wea_s   = 1'b0;
        addra_s = addra_r;
        dina_s  = dina_r;
        addrb_s = addrb_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    op_s    = op;
                    a_ptr_s = base_a;
                    b_ptr_s = base_b;
                    d_ptr_s = base_d;
                    len_s   = len;
                    cnt_s   = {LEN_W{1'b0}};
                    ovf_s   = 1'b0;
                    if (len == {LEN_W{1'b0}}) begin
                        state_s = FIN;
                        done_s  = 1'b1;
                    end else begin
                        state_s = RD_A;
                        busy_s  = 1'b1;
                        addrb_s = base_a;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RD_A: begin
                state_s = RD_B;
                busy_s  = 1'b1;
                addrb_s = b_ptr_r;
            end
            RD_B: begin
                // A data arrives now, one cycle after its address.
                state_s = EXEC;
                busy_s  = 1'b1;
                opa_s   = doutb;
            end
            EXEC: begin
                state_s = WR;
                busy_s  = 1'b1;
                wea_s   = 1'b1;
                addra_s = d_ptr_r;
                dina_s  = alu_res_s;
                ovf_s   = ovf_r | alu_ovf_s;
            end
            WR: begin
                a_ptr_s = a_ptr_r + ADDR_ONE;
                b_ptr_s = b_ptr_r + ADDR_ONE;
                d_ptr_s = d_ptr_r + ADDR_ONE;
                cnt_s   = cnt_r + LEN_ONE;
                if (cnt_r == (len_r - LEN_ONE)) begin
                    state_s = FIN;
                    done_s  = 1'b1;
                end else begin
                    // Read address is issued after this write lands, so in-place runs chain.
                    state_s = RD_A;
                    busy_s  = 1'b1;
                    addrb_s = a_ptr_r + ADDR_ONE;
                end
            end
            FIN: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            op_r    <= 3'd0;
            a_ptr_r <= {ADDR_W{1'b0}};
            b_ptr_r <= {ADDR_W{1'b0}};
            d_ptr_r <= {ADDR_W{1'b0}};
            len_r   <= {LEN_W{1'b0}};
            cnt_r   <= {LEN_W{1'b0}};
            opa_r   <= {DATA_W{1'b0}};
            ovf_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            wea_r   <= 1'b0;
            addra_r <= {ADDR_W{1'b0}};
            dina_r  <= {DATA_W{1'b0}};
            addrb_r <= {ADDR_W{1'b0}};
        end else begin
            state_r <= state_s;
            op_r    <= op_s;
            a_ptr_r <= a_ptr_s;
            b_ptr_r <= b_ptr_s;
            d_ptr_r <= d_ptr_s;
            len_r   <= len_s;
            cnt_r   <= cnt_s;
            opa_r   <= opa_s;
            ovf_r   <= ovf_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            wea_r   <= wea_s;
            addra_r <= addra_s;
            dina_r  <= dina_s;
            addrb_r <= addrb_s;
        end
    end

    assign busy  = busy_r;
    assign done  = done_r;
    assign ovf   = ovf_r;
    assign wea   = wea_r;
    assign addra = addra_r;
    assign dina  = dina_r;
    assign addrb = addrb_r;

endmodule

// File: tb/tb_mem_vec_engine.sv
// Bench for mem_vec_engine: behavioural dual-port memory, a write scoreboard
// fed when each run is set up, a vector table of single-element ops, and
// hand-written sequences for multi-element, wrap, len=0, reset and re-start cases.
module tb_mem_vec_engine;
    import mem_vec_pkg::*;

    localparam int DW = 32;
    localparam int AW = 6;
    localparam int LW = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [2:0]    op;
    logic [AW-1:0] base_a, base_b, base_d;
    logic [LW-1:0] len;
    logic          busy, done, ovf, wea;
    logic [AW-1:0] addra, addrb;
    logic [DW-1:0] dina, doutb;

    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;
    logic [DW-1:0] mem [0:63];

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;
    wr_t exp_q[$];

    typedef struct packed {
        logic [2:0]    op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] d;
        logic          ovf;
    } vec_t;
    vec_t vecs [14];

    mem_vec_engine #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .base_a (base_a),
        .base_b (base_b),
        .base_d (base_d),
        .len    (len),
        .busy   (busy),
        .done   (done),
        .ovf    (ovf),
        .wea    (wea),
        .addra  (addra),
        .dina   (dina),
        .addrb  (addrb),
        .doutb  (doutb)
    );

    always #5 clk = ~clk;

    // Memory model: preload port has priority, synchronous read with 1-cycle latency.
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (wea) mem[addra] <= dina;
        doutb <= mem[addrb];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_t e;
        e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    // Start a run and wait for done; poke_at>0 fires a stray start at that cycle.
    task automatic run(input logic [2:0] o, input logic [AW-1:0] ba, input logic [AW-1:0] bb,
                       input logic [AW-1:0] bd, input logic [LW-1:0] n, input int poke_at);
        int cyc;
        bit seen;
        int dc0;
        dc0 = done_cnt;
        op = o; base_a = ba; base_b = bb; base_d = bd; len = n;
        start = 1'b1;
        cyc = 0; seen = 1'b0;
        while (cyc < 4 * int'(n) + 20 && !seen) begin
            @(negedge clk);
            cyc++;
            start = (poke_at != 0 && cyc == poke_at);
            if (start) begin
                op = OP_SUB; base_d = bd + 6'd1; len = 7'd1;
            end
            if (cyc == 1 && n != 7'd0) check("busy_after_start", 64'(busy), 64'd1);
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        if (!seen) begin
            total++; bad++;
            $display("FAIL done_timeout: got no done after %0d cycles expected done at %0d", cyc, 4 * int'(n) + 1);
        end else begin
            check("done_latency", 64'(cyc), 64'(4 * int'(n) + 1));
            check("busy_at_done", 64'(busy), 64'd0);
        end
        repeat (3) @(negedge clk);
        check("done_pulses", 64'(done_cnt - dc0), 64'd1);
        check("writes_drained", 64'(exp_q.size()), 64'd0);
    endtask

    // Write monitor: every wea cycle must match the next expected write.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (wea) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_write: got addr=%0d data=%0h expected no write", addra, dina);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 64'(addra), 64'(e.addr));
                    check("wr_data", 64'(dina), 64'(e.data));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        vecs[0]  = '{OP_ADD, 32'd5,          32'd7,          32'd12,         1'b0};
        vecs[1]  = '{OP_ADD, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  1'b1};
        vecs[2]  = '{OP_SUB, 32'd5,          32'd3,          32'd2,          1'b0};
        vecs[3]  = '{OP_ADD, 32'h8000_0000,  32'h8000_0000,  32'h0000_0000,  1'b1};
        vecs[4]  = '{OP_SUB, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  1'b1};
        vecs[5]  = '{OP_SUB, 32'd3,          32'd5,          32'hFFFF_FFFE,  1'b0};
        vecs[6]  = '{OP_AND, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000,  1'b0};
        vecs[7]  = '{OP_OR,  32'hF0F0_F0F0,  32'h0F0F_0000,  32'hFFFF_F0F0,  1'b0};
        vecs[8]  = '{OP_XOR, 32'hAAAA_AAAA,  32'hFFFF_FFFF,  32'h5555_5555,  1'b0};
        vecs[9]  = '{OP_SLT, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0};
        vecs[10] = '{OP_SLT, 32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};
        vecs[11] = '{OP_SLL, 32'd1,          32'h0000_0024,  32'h0000_0010,  1'b0};
        vecs[12] = '{OP_SRL, 32'h8000_0000,  32'h0000_001F,  32'd1,          1'b0};
        vecs[13] = '{OP_SRL, 32'h8000_0000,  32'h0000_0021,  32'h4000_0000,  1'b0};

        rst = 1'b1; start = 1'b0; op = 3'd0; base_a = '0; base_b = '0; base_d = '0; len = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({busy, done, ovf, wea, addra, dina, addrb}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // ADD len=4 with a stray start mid-run that must be ignored.
        for (int i = 0; i < 4; i++) begin
            poke(6'(i), 32'(i + 1));
            poke(6'(8 + i), 32'(10 * (i + 1)));
        end
        push(6'd16, 32'd11); push(6'd17, 32'd22); push(6'd18, 32'd33); push(6'd19, 32'd44);
        run(OP_ADD, 6'd0, 6'd8, 6'd16, 7'd4, 6);
        check("add4_ovf", 64'(ovf), 64'd0);
        check("add4_mem19", 64'(mem[19]), 64'd44);

        // Single-element op table; ovf checked after each run.
        for (int i = 0; i < 14; i++) begin
            poke(6'd40, vecs[i].a);
            poke(6'd41, vecs[i].b);
            push(6'd42, vecs[i].d);
            run(vecs[i].op, 6'd40, 6'd41, 6'd42, 7'd1, 0);
            check($sformatf("vec%0d_ovf", i), 64'(ovf), 64'(vecs[i].ovf));
        end

        // len=0 right after an overflowing run: done next cycle, no writes, ovf cleared.
        poke(6'd40, 32'h7FFF_FFFF);
        poke(6'd41, 32'd1);
        push(6'd42, 32'h8000_0000);
        run(OP_ADD, 6'd40, 6'd41, 6'd42, 7'd1, 0);
        check("pre_len0_ovf", 64'(ovf), 64'd1);
        run(OP_ADD, 6'd0, 6'd0, 6'd0, 7'd0, 0);
        check("len0_ovf_cleared", 64'(ovf), 64'd0);

        // Wrap and in-place XOR.
        poke(6'd62, 32'h12); poke(6'd63, 32'h34);
        for (int i = 0; i < 4; i++) poke(6'(i), 32'hFF);
        push(6'd62, 32'hED); push(6'd63, 32'hCB); push(6'd0, 32'h0); push(6'd1, 32'h0);
        run(OP_XOR, 6'd62, 6'd0, 6'd62, 7'd4, 0);
        check("wrap_mem62", 64'(mem[62]), 64'hED);
        check("wrap_mem63", 64'(mem[63]), 64'hCB);
        check("wrap_mem0", 64'(mem[0]), 64'h0);
        check("wrap_mem1", 64'(mem[1]), 64'h0);
        check("wrap_mem2", 64'(mem[2]), 64'hFF);

        // Reset during the second element's EXEC.
        poke(6'd20, 32'h7FFF_FFFF); poke(6'd21, 32'd5);
        poke(6'd24, 32'd1);         poke(6'd25, 32'd2);
        poke(6'd28, 32'hAAAA);      poke(6'd29, 32'hBBBB);
        push(6'd28, 32'h8000_0000);
        dc = done_cnt;
        op = OP_ADD; base_a = 6'd20; base_b = 6'd24; base_d = 6'd28; len = 7'd3;
        start = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("ovf_before_rst", 64'(ovf), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_outputs", 64'({busy, done, ovf, wea}), 64'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("rst_mem28", 64'(mem[28]), 64'h8000_0000);
        check("rst_mem29", 64'(mem[29]), 64'hBBBB);
        check("rst_no_done", 64'(done_cnt - dc), 64'd0);
        check("rst_writes_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
